// File: rtl/bpsk_pkg.sv
// Shared encodings for the BPSK framed bit-stream source: payload modes,
// framer FSM states and PRBS polynomial taps.
package bpsk_pkg;

  localparam logic [1:0] MODE_ROT    = 2'd0;
  localparam logic [1:0] MODE_PRBS7  = 2'd1;
  localparam logic [1:0] MODE_PRBS15 = 2'd2;
  localparam logic [1:0] MODE_ONES   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Taps are polynomial exponents: x^ORDER + x^TAP_B + 1 with TAP_A == ORDER.
  localparam int PRBS7_ORDER  = 7;
  localparam int PRBS7_TAP_A  = 7;
  localparam int PRBS7_TAP_B  = 6;
  localparam int PRBS15_ORDER = 15;
  localparam int PRBS15_TAP_A = 15;
  localparam int PRBS15_TAP_B = 14;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bpsk_prbs_gen.sv
// Fibonacci PRBS generator seeded with all ones; shifts once per adv pulse.
// o_nxt is the bit that o_bit will show after the next advance.
module bpsk_prbs_gen
  import bpsk_pkg::*;
#(
  parameter int ORDER = PRBS7_ORDER,
  parameter int TAP_A = PRBS7_TAP_A,
  parameter int TAP_B = PRBS7_TAP_B
) (
  input  logic gclk1,
  input  logic rst,
  input  logic adv,
  output logic o_bit,
  output logic o_nxt
);

  logic [ORDER-1:0] r_s;

  // LFSR state: feedback enters at bit 0, output taken from the MSB
  always_ff @(posedge gclk1 or posedge rst) begin
    if (rst) begin
      r_s <= '1;
    end else if (adv) begin
      r_s <= {r_s[ORDER-2:0], r_s[TAP_A-1] ^ r_s[TAP_B-1]};
    end else begin
      r_s <= r_s;
    end
  end

  assign o_bit = r_s[ORDER-1];
  assign o_nxt = r_s[ORDER-2];

endmodule

// File: rtl/bpsk_frame_src.sv
// Framed bit-stream source for the BPSK transmitter: preamble, payload from a
// selectable pattern, then an idle gap, over a valid/ready handshake.
module bpsk_frame_src
  import bpsk_pkg::*;
#(
  parameter int              PAT_W     = 10,
  parameter logic [PAT_W-1:0] PAT_INIT = 10'b1101011001,
  parameter int              PRE_LEN   = 16,
  parameter int              FRAME_LEN = 64,
  parameter int              GAP_LEN   = 8,
  parameter int              CNT_W     = 16
) (
  input  logic             gclk1,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             iready,
  output logic             odata,
  output logic             ovalid,
  output logic             osof,
  output logic             oeof,
  output logic             in_payload,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int MAX_LEN = max3(PRE_LEN, FRAME_LEN, GAP_LEN);
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [PAT_W-1:0] r_pat;
  logic w_xfer, w_start, w_bound;
  logic w_adv_rot, w_adv_p7, w_adv_p15;
  logic w_p7_bit, w_p7_nxt, w_p15_bit, w_p15_nxt;
  logic w_src_nxt, w_odata_nxt, w_valid_nxt, w_sof_nxt, w_eof_nxt, w_pay_nxt;
  logic r_odata, r_ovalid, r_osof, r_oeof, r_in_payload, r_busy;

  assign w_xfer = r_ovalid & iready;

  bpsk_prbs_gen #(.ORDER(PRBS7_ORDER), .TAP_A(PRBS7_TAP_A), .TAP_B(PRBS7_TAP_B)) u_prbs7 (
    .gclk1(gclk1), .rst(rst), .adv(w_adv_p7), .o_bit(w_p7_bit), .o_nxt(w_p7_nxt)
  );

  bpsk_prbs_gen #(.ORDER(PRBS15_ORDER), .TAP_A(PRBS15_TAP_A), .TAP_B(PRBS15_TAP_B)) u_prbs15 (
    .gclk1(gclk1), .rst(rst), .adv(w_adv_p15), .o_bit(w_p15_bit), .o_nxt(w_p15_nxt)
  );

  // Framer next-state: bit counting, source advance, frame-boundary decision
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mode_nxt      = r_mode;
    w_frame_cnt_nxt = r_frame_cnt;
    w_adv_rot       = 1'b0;
    w_adv_p7        = 1'b0;
    w_adv_p15       = 1'b0;
    w_start         = 1'b0;
    w_bound         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_start = 1'b1;
        else    w_state_nxt = ST_IDLE;
      end
      ST_PRE: begin
        if (w_xfer) begin
          if (r_cnt == PRE_LAST) begin
            w_state_nxt = ST_PAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_PAY: begin
        if (w_xfer) begin
          case (r_mode)
            MODE_ROT:    w_adv_rot = 1'b1;
            MODE_PRBS7:  w_adv_p7  = 1'b1;
            MODE_PRBS15: w_adv_p15 = 1'b1;
            default:     w_adv_rot = 1'b0;
          endcase
          if (r_cnt == PAY_LAST) begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
            if (GAP_LEN > 0) begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = '0;
            end else begin
              w_bound = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) w_bound = 1'b1;
        else                   w_cnt_nxt = r_cnt + CW'(1);
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_bound) begin
      if (en) begin
        w_start = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    end else begin
      w_start = w_start;
    end

    if (w_start) begin
      w_mode_nxt  = mode;
      w_cnt_nxt   = '0;
      w_state_nxt = (PRE_LEN > 0) ? ST_PRE : ST_PAY;
    end else begin
      w_mode_nxt = w_mode_nxt;
    end
  end

  // Output lookahead: what the registered outputs must show after this edge
  always_comb begin
    case (w_mode_nxt)
      MODE_ROT:    w_src_nxt = w_adv_rot ? r_pat[PAT_W-1] : r_pat[0];
      MODE_PRBS7:  w_src_nxt = w_adv_p7  ? w_p7_nxt  : w_p7_bit;
      MODE_PRBS15: w_src_nxt = w_adv_p15 ? w_p15_nxt : w_p15_bit;
      default:     w_src_nxt = 1'b1;
    endcase
    w_valid_nxt = 1'b0;
    w_odata_nxt = 1'b0;
    w_sof_nxt   = 1'b0;
    w_eof_nxt   = 1'b0;
    w_pay_nxt   = 1'b0;
    case (w_state_nxt)
      ST_PRE: begin
        w_valid_nxt = 1'b1;
        w_odata_nxt = ~w_cnt_nxt[0];
        w_sof_nxt   = (w_cnt_nxt == '0);
      end
      ST_PAY: begin
        w_valid_nxt = 1'b1;
        w_pay_nxt   = 1'b1;
        w_odata_nxt = w_src_nxt;
        w_sof_nxt   = (PRE_LEN == 0) && (w_cnt_nxt == '0);
        w_eof_nxt   = (w_cnt_nxt == PAY_LAST);
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Rotating pattern word advances only on its own payload transfers
  always_ff @(posedge gclk1 or posedge rst) begin
    if (rst) begin
      r_pat <= PAT_INIT;
    end else if (w_adv_rot) begin
      r_pat <= {r_pat[PAT_W-2:0], r_pat[PAT_W-1]};
    end else begin
      r_pat <= r_pat;
    end
  end

  // FSM, counters and registered outputs
  always_ff @(posedge gclk1 or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mode       <= MODE_ROT;
      r_frame_cnt  <= '0;
      r_odata      <= 1'b0;
      r_ovalid     <= 1'b0;
      r_osof       <= 1'b0;
      r_oeof       <= 1'b0;
      r_in_payload <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_odata      <= w_odata_nxt;
      r_ovalid     <= w_valid_nxt;
      r_osof       <= w_sof_nxt;
      r_oeof       <= w_eof_nxt;
      r_in_payload <= w_pay_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign odata      = r_odata;
  assign ovalid     = r_ovalid;
  assign osof       = r_osof;
  assign oeof       = r_oeof;
  assign in_payload = r_in_payload;
  assign busy       = r_busy;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_bpsk_frame_src.sv
// Directed self-checking bench for bpsk_frame_src: default framing, backpressure,
// PRBS7, en drop, degenerate back-to-back frames and mid-frame reset.
module tb_bpsk_frame_src;

  logic        gclk1, rst;
  logic        en, iready, odata, ovalid, osof, oeof, in_payload, busy;
  logic [1:0]  mode;
  logic [15:0] frame_cnt;
  logic        en_b, iready_b, odata_b, ovalid_b, osof_b, oeof_b, in_payload_b, busy_b;
  logic [1:0]  mode_b;
  logic [15:0] frame_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int rot_pos = 0;
  logic [9:0] rot_vec = 10'b0011010111;  // bit k = k-th rotating payload bit
  logic [3:0] cap [0:255];               // {odata, osof, oeof, in_payload}
  logic pay_q [$];

  bpsk_frame_src dut (
    .gclk1(gclk1), .rst(rst), .en(en), .mode(mode), .iready(iready),
    .odata(odata), .ovalid(ovalid), .osof(osof), .oeof(oeof),
    .in_payload(in_payload), .busy(busy), .frame_cnt(frame_cnt)
  );

  bpsk_frame_src #(.PRE_LEN(0), .FRAME_LEN(1), .GAP_LEN(0)) dut_b (
    .gclk1(gclk1), .rst(rst), .en(en_b), .mode(mode_b), .iready(iready_b),
    .odata(odata_b), .ovalid(ovalid_b), .osof(osof_b), .oeof(oeof_b),
    .in_payload(in_payload_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  initial gclk1 = 1'b0;
  always #5 gclk1 = ~gclk1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge gclk1);
    #1;
  endtask

  // Expected {data, sof, eof, payload} for bit i of a default mode-0 frame
  function automatic logic [3:0] exp_rot(input int i, input int pos);
    logic d;
    if (i < 16) d = (i % 2 == 0);
    else        d = rot_vec[(pos + i - 16) % 10];
    return {d, (i == 0), (i == 79), (i >= 16)};
  endfunction

  task automatic collect_frame(input bit rnd, input int drop_at,
                               output int nbits, output int viol, output bit tmo);
    logic       held;
    logic [3:0] hv;
    int         npay;
    nbits = 0; viol = 0; tmo = 1'b1; held = 1'b0; npay = 0; hv = 4'd0;
    for (int c = 0; c < 2000; c++) begin
      if (held) begin
        if (ovalid !== 1'b1 || {odata, osof, oeof, in_payload} !== hv) viol++;
      end
      iready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ovalid === 1'b1 && iready) begin
        if (nbits < 256) cap[nbits] = {odata, osof, oeof, in_payload};
        nbits++;
        held = 1'b0;
        if (in_payload === 1'b1) begin
          if (npay == drop_at) en = 1'b0;
          npay++;
        end
        if (oeof === 1'b1 || nbits >= 256) begin
          tmo = (oeof !== 1'b1);
          cyc();
          break;
        end
      end else if (ovalid === 1'b1) begin
        held = 1'b1;
        hv   = {odata, osof, oeof, in_payload};
      end else begin
        held = 1'b0;
      end
      cyc();
    end
  endtask

  task automatic wait_valid(output int low, output bit tmo);
    low = 0; tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (ovalid === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      low++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; iready = 1'b0;
    en_b = 1'b0; mode_b = 2'd3; iready_b = 1'b0;
    repeat (3) cyc();
    n_tests++;
    if ({odata, ovalid, osof, oeof, in_payload, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000", {odata, ovalid, osof, oeof, in_payload, busy});
    end
    n_tests++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
    n_tests++;
    if ({odata_b, ovalid_b, osof_b, oeof_b, in_payload_b, busy_b, frame_cnt_b} !== 22'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b want 0", {odata_b, ovalid_b, osof_b, oeof_b, in_payload_b, busy_b, frame_cnt_b});
    end
  endtask

  task automatic test_default_frame();
    int nb, viol, low;
    bit tmo;
    logic [3:0] e;
    mode = 2'd0; en = 1'b1; iready = 1'b1;
    rst = 1'b0;
    cyc();
    collect_frame(1'b0, -1, nb, viol, tmo);
    n_tests++;
    if (tmo || nb != 80) begin
      n_fail++;
      $display("FAIL frame1_len: got %0d bits (timeout %0d) want 80", nb, tmo);
    end
    for (int i = 0; i < 80; i++) begin
      e = exp_rot(i, rot_pos);
      n_tests++;
      if (cap[i] !== e) begin
        n_fail++;
        $display("FAIL frame1_bit%0d: got %b want %b", i, cap[i], e);
      end
    end
    rot_pos = (rot_pos + 64) % 10;
    n_tests++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL frame1_cnt: got %0d want 1", frame_cnt);
    end
    n_tests++;
    if ({busy, ovalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL frame1_gap_state: got busy,ovalid=%b want 10", {busy, ovalid});
    end
    wait_valid(low, tmo);
    n_tests++;
    if (tmo || low != 8) begin
      n_fail++;
      $display("FAIL frame1_gap_len: got %0d (timeout %0d) want 8", low, tmo);
    end
  endtask

  task automatic test_backpressure();
    int nb, viol;
    bit tmo;
    logic [3:0] e;
    collect_frame(1'b1, -1, nb, viol, tmo);
    iready = 1'b1;
    n_tests++;
    if (tmo || nb != 80) begin
      n_fail++;
      $display("FAIL bp_len: got %0d bits (timeout %0d) want 80", nb, tmo);
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL bp_stall_stable: got %0d violations want 0", viol);
    end
    for (int i = 0; i < 80; i++) begin
      e = exp_rot(i, rot_pos);
      n_tests++;
      if (cap[i] !== e) begin
        n_fail++;
        $display("FAIL bp_bit%0d: got %b want %b", i, cap[i], e);
      end
    end
    rot_pos = (rot_pos + 64) % 10;
    n_tests++;
    if (frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d want 2", frame_cnt);
    end
    mode = 2'd1;  // latched at the next frame boundary
  endtask

  task automatic test_prbs7();
    int nb, viol, low, errs;
    bit tmo, any_tmo;
    logic [6:0] s;
    logic [7:0] first8;
    pay_q.delete();
    any_tmo = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_valid(low, tmo);
      any_tmo |= tmo;
      collect_frame(1'b0, -1, nb, viol, tmo);
      any_tmo |= tmo;
      for (int i = 0; i < nb && i < 256; i++)
        if (cap[i][0] === 1'b1) pay_q.push_back(cap[i][3]);
    end
    n_tests++;
    if (any_tmo || pay_q.size() != 192) begin
      n_fail++;
      $display("FAIL prbs7_len: got %0d payload bits (timeout %0d) want 192", pay_q.size(), any_tmo);
    end
    first8 = 8'd0;
    for (int j = 0; j < 8 && j < pay_q.size(); j++) first8[7-j] = pay_q[j];
    n_tests++;
    if (first8 !== 8'b11111110) begin
      n_fail++;
      $display("FAIL prbs7_first8: got %b want 11111110", first8);
    end
    s = 7'h7F;
    errs = 0;
    for (int j = 0; j < pay_q.size(); j++) begin
      if (pay_q[j] !== s[6]) errs++;
      s = {s[5:0], s[6] ^ s[5]};
      if (j == 126) begin
        n_tests++;
        if (s !== 7'h7F) begin
          n_fail++;
          $display("FAIL prbs7_model_period: got %h want 7f", s);
        end
      end
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL prbs7_stream: got %0d bit errors want 0", errs);
    end
    n_tests++;
    if (frame_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL prbs7_cnt: got %0d want 5", frame_cnt);
    end
  endtask

  task automatic test_en_drop();
    int nb, viol, low;
    bit tmo;
    wait_valid(low, tmo);
    collect_frame(1'b0, 10, nb, viol, tmo);
    n_tests++;
    if (tmo || nb != 80 || cap[79][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL endrop_complete: got %0d bits eof=%b (timeout %0d) want 80 eof=1", nb, cap[79][1], tmo);
    end
    n_tests++;
    if (frame_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL endrop_cnt: got %0d want 6", frame_cnt);
    end
    repeat (7) cyc();
    n_tests++;
    if ({busy, ovalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL endrop_gap: got busy,ovalid=%b want 10", {busy, ovalid});
    end
    cyc();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_idle: got busy=%b want 0", busy);
    end
    repeat (20) cyc();
    n_tests++;
    if ({busy, ovalid, frame_cnt} !== {2'b00, 16'd6}) begin
      n_fail++;
      $display("FAIL endrop_stays_idle: got busy,ovalid=%b cnt=%0d want 00 cnt=6", {busy, ovalid}, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int xf;
    mode_b = 2'd3; iready_b = 1'b1; en_b = 1'b1;
    cyc();
    xf = 0;
    for (int c = 0; c < 40; c++) begin
      n_tests++;
      if ({ovalid_b, osof_b, oeof_b, in_payload_b, odata_b} !== 5'b11111) begin
        n_fail++;
        $display("FAIL b2b_flags_c%0d: got %b want 11111", c, {ovalid_b, osof_b, oeof_b, in_payload_b, odata_b});
      end
      n_tests++;
      if (frame_cnt_b !== 16'(xf)) begin
        n_fail++;
        $display("FAIL b2b_cnt_c%0d: got %0d want %0d", c, frame_cnt_b, xf);
      end
      iready_b = (c < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      if (iready_b) xf++;
      cyc();
    end
    n_tests++;
    if (frame_cnt_b !== 16'(xf)) begin
      n_fail++;
      $display("FAIL b2b_cnt_final: got %0d want %0d", frame_cnt_b, xf);
    end
    en_b = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int nb, viol;
    bit tmo;
    logic [3:0] e;
    en = 1'b1; mode = 2'd0; iready = 1'b1;
    repeat (3) cyc();
    n_tests++;
    if ({ovalid, in_payload} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_pre: got ovalid,in_payload=%b want 10", {ovalid, in_payload});
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({odata, ovalid, osof, oeof, in_payload, busy, frame_cnt} !== 22'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b want 0", {odata, ovalid, osof, oeof, in_payload, busy, frame_cnt});
    end
    cyc();
    rst = 1'b0;
    cyc();
    collect_frame(1'b0, -1, nb, viol, tmo);
    n_tests++;
    if (tmo || nb != 80) begin
      n_fail++;
      $display("FAIL rstmid_len: got %0d bits (timeout %0d) want 80", nb, tmo);
    end
    for (int i = 0; i < 80; i++) begin
      e = exp_rot(i, 0);
      n_tests++;
      if (cap[i] !== e) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d: got %b want %b", i, cap[i], e);
      end
    end
    n_tests++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got %0d want 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_backpressure();
    test_prbs7();
    test_en_drop();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
